cache_mem_arbiter: RTL and testbench



---
 rtl/cache_mem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// cache_mem_arbiter
//
// Shares one external memory port between two cache masters:
// s0 is the instruction cache and s1 is the data cache. Only one transaction
// is outstanding at a time. Read data is broadcast to both masters, and only
// the valid pulse is steered to the master that issued the read.
//
// Handshake (both sides): a master asserts read or write and holds addr,
// byte_en and writedata stable while waitrequest is high. The command is
// accepted on the first cycle the command is presented with waitrequest low.
// Read data is presented on the cycle readdata_valid is high (one-cycle pulse).
//
// Configuration macro: CACHE_ARB_RR_EN
//   defined   : round-robin. On a tie the master that did not win last time
//               gets the grant.
//   undefined : fixed priority. s1 (dcache) wins every tie.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_sX_addr/byte_en/
//   writedata/read/write       master X command (X = 0 icache, 1 dcache)
//   o_sX_readdata/_valid       read data (always i_m_readdata) and steered valid
//   o_sX_waitrequest           stall towards master X
//   o_m_addr/byte_en/
//   writedata/read/write       memory command
//   i_m_readdata/_valid        memory read response
//   i_m_waitrequest            memory stall
//   o_dbg_state                current FSM state (0 IDLE, 1 CMD, 2 RESP)
// ---------------------------------------------------------------------------
module cache_mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 128,
  parameter int BW = DW / 8
) (
  input  logic          clk,
  input  logic          rst_n,
  // master 0 (icache)
  input  logic [AW-1:0] i_s0_addr,
  input  logic [BW-1:0] i_s0_byte_en,
  input  logic [DW-1:0] i_s0_writedata,
  input  logic          i_s0_read,
  input  logic          i_s0_write,
  output logic [DW-1:0] o_s0_readdata,
  output logic          o_s0_readdata_valid,
  output logic          o_s0_waitrequest,
  // master 1 (dcache)
  input  logic [AW-1:0] i_s1_addr,
  input  logic [BW-1:0] i_s1_byte_en,
  input  logic [DW-1:0] i_s1_writedata,
  input  logic          i_s1_read,
  input  logic          i_s1_write,
  output logic [DW-1:0] o_s1_readdata,
  output logic          o_s1_readdata_valid,
  output logic          o_s1_waitrequest,
  // memory port
  output logic [AW-1:0] o_m_addr,
  output logic [BW-1:0] o_m_byte_en,
  output logic [DW-1:0] o_m_writedata,
  output logic          o_m_read,
  output logic          o_m_write,
  input  logic [DW-1:0] i_m_readdata,
  input  logic          i_m_readdata_valid,
  input  logic          i_m_waitrequest,
  // debug
  output logic [1:0]    o_dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMD  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic       r_grant;
  logic       w_grant_nxt;
  logic       r_last;
  logic       w_last_nxt;

  logic       w_s0_req;
  logic       w_s1_req;
  logic       w_win;
  logic       w_g_read;
  logic       w_g_write;
  logic       w_route;

  assign w_s0_req = i_s0_read | i_s0_write;
  assign w_s1_req = i_s1_read | i_s1_write;

  // Winner of the IDLE-cycle decision (only used when some request exists).
  always_comb begin
    w_win = w_s1_req;
`ifdef CACHE_ARB_RR_EN
    if (w_s0_req && w_s1_req) begin
      w_win = ~r_last;
    end
`endif
  end

  // Granted master's command; read dominates a (illegal) read+write.
  assign w_g_read  = r_grant ? i_s1_read : i_s0_read;
  assign w_g_write = (r_grant ? i_s1_write : i_s0_write) & ~w_g_read;

  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_last_nxt       = r_last;
    w_route          = 1'b0;
    o_m_addr         = '0;
    o_m_byte_en      = '0;
    o_m_writedata    = '0;
    o_m_read         = 1'b0;
    o_m_write        = 1'b0;
    o_s0_waitrequest = 1'b1;
    o_s1_waitrequest = 1'b1;

    case (r_state)
      S_IDLE: begin
        if (w_s0_req || w_s1_req) begin
          w_grant_nxt = w_win;
          w_state_nxt = S_CMD;
        end
      end

      S_CMD: begin
        o_m_addr      = r_grant ? i_s1_addr      : i_s0_addr;
        o_m_byte_en   = r_grant ? i_s1_byte_en   : i_s0_byte_en;
        o_m_writedata = r_grant ? i_s1_writedata : i_s0_writedata;
        o_m_read      = w_g_read;
        o_m_write     = w_g_write;
        o_s0_waitrequest = r_grant ? 1'b1 : i_m_waitrequest;
        o_s1_waitrequest = r_grant ? i_m_waitrequest : 1'b1;

        if (!(w_g_read || w_g_write)) begin
          // Master withdrew its request: abandon without a command.
          w_state_nxt = S_IDLE;
        end else if (!i_m_waitrequest) begin
          if (w_g_write) begin
            w_last_nxt  = r_grant;
            w_state_nxt = S_IDLE;
          end else if (i_m_readdata_valid) begin
            // Zero-latency read: data returns in the accept cycle.
            w_route     = 1'b1;
            w_last_nxt  = r_grant;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_RESP;
          end
        end
      end

      S_RESP: begin
        if (i_m_readdata_valid) begin
          w_route     = 1'b1;
          w_last_nxt  = r_grant;
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_grant <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Data is broadcast; only the valid pulse is steered to the requester.
  assign o_s0_readdata       = i_m_readdata;
  assign o_s1_readdata       = i_m_readdata;
  assign o_s0_readdata_valid = w_route & ~r_grant;
  assign o_s1_readdata_valid = w_route &  r_grant;
  assign o_dbg_state         = r_state;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 128;
  localparam int BW = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] s0_addr, s1_addr;
  logic [BW-1:0] s0_be, s1_be;
  logic [DW-1:0] s0_wd, s1_wd;
  logic          s0_rd, s0_wr, s1_rd, s1_wr;
  logic [DW-1:0] s0_rdata, s1_rdata;
  logic          s0_rvalid, s1_rvalid, s0_wait, s1_wait;
  logic [AW-1:0] m_addr;
  logic [BW-1:0] m_be;
  logic [DW-1:0] m_wd;
  logic          m_rd, m_wr;
  logic [DW-1:0] m_rdata;
  logic          m_rvalid, m_wait;
  logic [1:0]    dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  cache_mem_arbiter #(.AW(AW), .DW(DW), .BW(BW)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .i_s0_addr           (s0_addr),
    .i_s0_byte_en        (s0_be),
    .i_s0_writedata      (s0_wd),
    .i_s0_read           (s0_rd),
    .i_s0_write          (s0_wr),
    .o_s0_readdata       (s0_rdata),
    .o_s0_readdata_valid (s0_rvalid),
    .o_s0_waitrequest    (s0_wait),
    .i_s1_addr           (s1_addr),
    .i_s1_byte_en        (s1_be),
    .i_s1_writedata      (s1_wd),
    .i_s1_read           (s1_rd),
    .i_s1_write          (s1_wr),
    .o_s1_readdata       (s1_rdata),
    .o_s1_readdata_valid (s1_rvalid),
    .o_s1_waitrequest    (s1_wait),
    .o_m_addr            (m_addr),
    .o_m_byte_en         (m_be),
    .o_m_writedata       (m_wd),
    .o_m_read            (m_rd),
    .o_m_write           (m_wr),
    .i_m_readdata        (m_rdata),
    .i_m_readdata_valid  (m_rvalid),
    .i_m_waitrequest     (m_wait),
    .o_dbg_state         (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  // Entered with DUT in CMD granted to s1 (write 0x100); leaves it in IDLE.
  task automatic serve_s1_write();
    #1;
    chk("t2_s1_write", m_wr, 1'b1);
    chk("t2_s1_noread", m_rd, 1'b0);
    chk("t2_s1_be", m_be, 16'h000F);
    chk("t2_s1_addr", m_addr, 32'h100);
    chk("t2_s1_wait", s1_wait, 1'b0);
    chk("t2_s0_wait_blk", s0_wait, 1'b1);
    step();
    s1_wr = 1'b0;
    #1;
    chk("t2_after_wr_idle", dbg_state, ST_IDLE);
    chk("t2_after_wr_nocmd", m_wr, 1'b0);
  endtask

  // Entered with DUT in CMD granted to s0 (read 0x200); leaves it in IDLE.
  task automatic serve_s0_read();
    #1;
    chk("t2_s0_read", m_rd, 1'b1);
    chk("t2_s0_addr", m_addr, 32'h200);
    chk("t2_s1_wait_blk", s1_wait, 1'b1);
    step();
    s0_rd    = 1'b0;
    m_rdata  = {16{8'h3C}};
    m_rvalid = 1'b1;
    #1;
    chk("t2_s0_rvalid", s0_rvalid, 1'b1);
    chk("t2_s0_rdata", s0_rdata, {16{8'h3C}});
    chk("t2_s1_rvalid", s1_rvalid, 1'b0);
    step();
    m_rvalid = 1'b0;
    #1;
    chk("t2_after_rd_idle", dbg_state, ST_IDLE);
  endtask

  initial begin : main
    logic exp_g;
    int   cnt0;
    int   cnt1;

    rst_n   = 1'b0;
    s0_addr = '0; s0_be = '0; s0_wd = '0; s0_rd = 1'b0; s0_wr = 1'b0;
    s1_addr = '0; s1_be = '0; s1_wd = '0; s1_rd = 1'b0; s1_wr = 1'b0;
    m_rdata = {4{32'hDEAD_BEEF}};
    m_rvalid = 1'b0;
    m_wait   = 1'b0;

    // ---- reset values ----
    #2;
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_m_read", m_rd, 1'b0);
    chk("rst_m_write", m_wr, 1'b0);
    chk("rst_m_addr", m_addr, 32'h0);
    chk("rst_m_wd", m_wd, 128'h0);
    chk("rst_s0_wait", s0_wait, 1'b1);
    chk("rst_s1_wait", s1_wait, 1'b1);
    chk("rst_s0_rvalid", s0_rvalid, 1'b0);
    chk("rst_s1_rvalid", s1_rvalid, 1'b0);
    chk("rst_s0_rdata", s0_rdata, {4{32'hDEAD_BEEF}});
    #10;
    rst_n = 1'b1;

    // ---- single s0 read, data 3 cycles after accept ----
    step();
    s0_rd = 1'b1; s0_addr = 32'h40;
    #1;
    chk("t1_idle_noread", m_rd, 1'b0);
    chk("t1_idle_wait", s0_wait, 1'b1);
    step();
    #1;
    chk("t1_cmd_read", m_rd, 1'b1);
    chk("t1_cmd_addr", m_addr, 32'h40);
    chk("t1_cmd_wait", s0_wait, 1'b0);
    step();
    s0_rd = 1'b0;
    #1;
    chk("t1_resp_noread", m_rd, 1'b0);
    chk("t1_resp_state", dbg_state, ST_RESP);
    chk("t1_resp_wait", s0_wait, 1'b1);
    step();
    #1;
    chk("t1_resp_novalid", s0_rvalid, 1'b0);
    chk("t1_resp_noread2", m_rd, 1'b0);
    step();
    m_rdata = {16{8'hA5}}; m_rvalid = 1'b1;
    #1;
    chk("t1_s0_rvalid", s0_rvalid, 1'b1);
    chk("t1_s0_rdata", s0_rdata, {16{8'hA5}});
    chk("t1_s1_rvalid", s1_rvalid, 1'b0);
    step();
    m_rvalid = 1'b0;
    #1;
    chk("t1_back_idle", dbg_state, ST_IDLE);
    chk("t1_s0_rvalid_off", s0_rvalid, 1'b0);

    // ---- simultaneous s0 read / s1 write after reset ----
    do_reset();
    step();
    s0_rd = 1'b1; s0_addr = 32'h200;
    s1_wr = 1'b1; s1_addr = 32'h100; s1_be = 16'h000F; s1_wd = {4{32'h1111_2222}};
    step();
`ifdef CACHE_ARB_RR_EN
    serve_s0_read();
    step();
    serve_s1_write();
`else
    serve_s1_write();
    step();
    serve_s0_read();
`endif

    // ---- memory stall for 5 cycles during an s1 write ----
    step();
    s1_wr = 1'b1; s1_addr = 32'h300; s1_be = 16'hFFFF; s1_wd = {4{32'hCAFE_F00D}};
    m_wait = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_s1_wait_hi", s1_wait, 1'b1);
      chk("t3_s0_wait_hi", s0_wait, 1'b1);
      chk("t3_addr_stable", m_addr, 32'h300);
      chk("t3_wd_stable", m_wd, {4{32'hCAFE_F00D}});
      chk("t3_write_held", m_wr, 1'b1);
      step();
    end
    m_wait = 1'b0;
    #1;
    chk("t3_s1_wait_lo", s1_wait, 1'b0);
    chk("t3_s0_wait_still", s0_wait, 1'b1);
    step();
    s1_wr = 1'b0;
    #1;
    chk("t3_done_idle", dbg_state, ST_IDLE);

    // ---- read with data in the accept cycle ----
    s1_rd = 1'b1; s1_addr = 32'h400;
    step();
    m_rdata = {4{32'h1234_5678}}; m_rvalid = 1'b1;
    #1;
    chk("t4_cmd_read", m_rd, 1'b1);
    chk("t4_s1_rvalid", s1_rvalid, 1'b1);
    chk("t4_s1_rdata", s1_rdata, {4{32'h1234_5678}});
    chk("t4_s0_rvalid", s0_rvalid, 1'b0);
    step();
    s1_rd = 1'b0; m_rvalid = 1'b0;
    s0_rd = 1'b1; s0_addr = 32'h500;
    #1;
    chk("t4_idle_next", dbg_state, ST_IDLE);
    chk("t4_idle_noread", m_rd, 1'b0);
    step();
    #1;
    chk("t4_next_grant", dbg_state, ST_CMD);
    chk("t4_next_addr", m_addr, 32'h500);
    step();
    s0_rd = 1'b0;
    #1;
    chk("t5_in_resp", dbg_state, ST_RESP);

    // ---- reset pulsed while in RESP ----
    rst_n = 1'b0;
    #1;
    chk("t5_rst_state", dbg_state, ST_IDLE);
    chk("t5_rst_s0_wait", s0_wait, 1'b1);
    chk("t5_rst_m_read", m_rd, 1'b0);
    m_rvalid = 1'b1;
    #1;
    chk("t5_rst_s0_rvalid", s0_rvalid, 1'b0);
    step();
    rst_n = 1'b1;
    #1;
    chk("t5_late_s0_rvalid", s0_rvalid, 1'b0);
    chk("t5_late_s1_rvalid", s1_rvalid, 1'b0);
    step();
    #1;
    chk("t5_late_state", dbg_state, ST_IDLE);
    chk("t5_late_s0_rvalid2", s0_rvalid, 1'b0);
    m_rvalid = 1'b0;

    // ---- both masters read continuously, 10 each, 2-cycle latency ----
    do_reset();
    cnt0 = 10; cnt1 = 10;
    s0_rd = 1'b1; s0_addr = 32'hA000;
    s1_rd = 1'b1; s1_addr = 32'hB000;
    for (int k = 0; k < 20; k++) begin
`ifdef CACHE_ARB_RR_EN
      exp_g = (k % 2) == 1;
`else
      exp_g = (k < 10);
`endif
      step();
      #1;
      chk("t6_read", m_rd, 1'b1);
      chk("t6_addr", m_addr, exp_g ? 32'hB000 : 32'hA000);
      chk("t6_s0_wait", s0_wait, exp_g);
      chk("t6_s1_wait", s1_wait, !exp_g);
      step();
      #1;
      chk("t6_lat_novalid", s0_rvalid | s1_rvalid, 1'b0);
      step();
      m_rdata = 128'(k) + 128'h77; m_rvalid = 1'b1;
      #1;
      chk("t6_s0_rvalid", s0_rvalid, !exp_g);
      chk("t6_s1_rvalid", s1_rvalid, exp_g);
      step();
      m_rvalid = 1'b0;
      if (exp_g) cnt1--; else cnt0--;
      if (cnt0 == 0) s0_rd = 1'b0;
      if (cnt1 == 0) s1_rd = 1'b0;
      #1;
      chk("t6_idle", dbg_state, ST_IDLE);
    end
    step();
    #1;
    chk("t6_final_idle", dbg_state, ST_IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
